// File: rtl/motor_encoder_reader.sv
// Dual-wheel quadrature encoder reader: input sync, debounce, x4 decode into
// signed positions, and per-window saturating speed capture with error flags.
module motor_encoder_reader #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned WINDOW   = 1000000,
    parameter int unsigned POS_W    = 16,
    parameter int unsigned SPD_W    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       enc_a,
    input  logic [1:0]       enc_b,
    input  logic             clear,
    output logic [POS_W-1:0] pos_l,
    output logic [POS_W-1:0] pos_r,
    output logic [SPD_W-1:0] spd_l,
    output logic [SPD_W-1:0] spd_r,
    output logic             spd_valid,
    output logic [1:0]       err
);

    localparam int unsigned CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int unsigned WIN_W = $clog2(WINDOW);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [SPD_W-1:0] SPD_MAX  = {1'b0, {(SPD_W-1){1'b1}}};
    localparam logic [SPD_W-1:0] SPD_MIN  = {1'b1, {(SPD_W-1){1'b0}}};

    logic [1:0]            a_s1_q, a_s2_q, b_s1_q, b_s2_q;
    logic [1:0][1:0]       prev_q, filt_q, filt_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]            init_q, init_d;
    logic [1:0][POS_W-1:0] pos_q, pos_d;
    logic [1:0][SPD_W-1:0] acc_q, acc_d, spd_q, spd_d, acc_step;
    logic [WIN_W-1:0]      win_q, win_d;
    logic                  valid_q, valid_d;
    logic [1:0]            err_q, err_d;

    logic [1:0][1:0]       pair, dir;
    logic [1:0]            stable, accept, live, step_inc, step_dec, step_bad;
    logic                  win_end;

    // Position of an AB pair along the forward sequence 00,01,11,10.
    function automatic logic [1:0] seq_pos(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    always_comb begin
        pair     = '0;
        dir      = '0;
        stable   = '0;
        accept   = '0;
        live     = '0;
        step_inc = '0;
        step_dec = '0;
        step_bad = '0;
        filt_d   = filt_q;
        cnt_d    = '0;
        init_d   = init_q;
        pos_d    = pos_q;
        acc_step = acc_q;
        win_end  = (win_q == WIN_LAST);

        for (int w = 0; w < 2; w++) begin
            pair[w]   = {a_s2_q[w], b_s2_q[w]};
            stable[w] = (pair[w] != filt_q[w]) && (pair[w] == prev_q[w]);
            accept[w] = stable[w] && (cnt_q[w] == CNT_LAST);
            live[w]   = accept[w] && !init_q[w];
            dir[w]    = seq_pos(pair[w]) - seq_pos(filt_q[w]);

            step_inc[w] = live[w] && (dir[w] == 2'd1);
            step_dec[w] = live[w] && (dir[w] == 2'd3);
            step_bad[w] = live[w] && (dir[w] == 2'd2);

            if (stable[w] && !accept[w]) begin
                cnt_d[w] = cnt_q[w] + CNT_W'(1);
            end
            if (accept[w]) begin
                filt_d[w] = pair[w];
                init_d[w] = 1'b0;
            end

            // Position wraps freely; the window accumulator saturates.
            if (step_inc[w]) begin
                pos_d[w] = pos_q[w] + POS_W'(1);
                if (acc_q[w] != SPD_MAX) acc_step[w] = acc_q[w] + SPD_W'(1);
            end else if (step_dec[w]) begin
                pos_d[w] = pos_q[w] - POS_W'(1);
                if (acc_q[w] != SPD_MIN) acc_step[w] = acc_q[w] - SPD_W'(1);
            end
        end

        win_d   = win_end ? '0 : win_q + WIN_W'(1);
        valid_d = win_end;
        spd_d   = win_end ? acc_step : spd_q;
        acc_d   = win_end ? '0 : acc_step;
        err_d   = err_q | step_bad;

        // Clear overrides any step or window end in the same cycle.
        if (clear) begin
            pos_d   = '0;
            spd_d   = '0;
            acc_d   = '0;
            win_d   = '0;
            err_d   = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s1_q  <= '0;
            a_s2_q  <= '0;
            b_s1_q  <= '0;
            b_s2_q  <= '0;
            prev_q  <= '0;
            filt_q  <= '0;
            cnt_q   <= '0;
            init_q  <= 2'b11;
            pos_q   <= '0;
            acc_q   <= '0;
            spd_q   <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= '0;
        end else begin
            a_s1_q  <= enc_a;
            a_s2_q  <= a_s1_q;
            b_s1_q  <= enc_b;
            b_s2_q  <= b_s1_q;
            prev_q  <= pair;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            init_q  <= init_d;
            pos_q   <= pos_d;
            acc_q   <= acc_d;
            spd_q   <= spd_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign pos_l     = pos_q[0];
    assign pos_r     = pos_q[1];
    assign spd_l     = spd_q[0];
    assign spd_r     = spd_q[1];
    assign spd_valid = valid_q;
    assign err       = err_q;

endmodule
